// File: rtl/sa_pkg.sv
// sa_pkg: shared state encoding and default widths for the systolic-array job controller
package sa_pkg;
  localparam int WL_D = 16;
  localparam int AW_D = 10;
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
endpackage

// File: rtl/sa_job_ctrl_if.sv
// sa_job_ctrl_if: array-feed stream from the job controller into the systolic array
interface sa_job_ctrl_if #(
  parameter int R  = 4,
  parameter int C  = 8,
  parameter int WX = 4,
  parameter int WK = 8
);
  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [R*WX-1:0] sx_data;
  logic [C*WK-1:0] sk_data;
  modport master(output s_valid, s_last, sx_data, sk_data, input s_ready);
  modport slave(input s_valid, s_last, sx_data, sk_data, output s_ready);
endinterface

// File: rtl/sa_skid_fifo.sv
// sa_skid_fifo: 2-entry fall-through FIFO; an empty FIFO presents the incoming word directly
module sa_skid_fifo #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic         head, tail, store, take;
  // a word popped in the same cycle it arrives into an empty FIFO is never stored
  assign store = push && !(pop && occ == 2'd0);
  assign take  = pop && occ != 2'd0;
  assign valid = occ != 2'd0 || push;
  assign dout  = occ != 2'd0 ? mem[head] : push ? din : '0;
  always_ff @(posedge clk) begin
    if (store) mem[tail] <= din;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      occ  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
    end else begin
      if (store) tail <= ~tail;
      if (take) head <= ~head;
      occ <= occ + 2'(store) - 2'(take);
    end
  end
endmodule

// File: rtl/sa_job_ctrl.sv
// sa_job_ctrl: accepts a tiled job, streams x/k buffer reads into the array and tracks completion
module sa_job_ctrl
  import sa_pkg::*;
#(
  parameter int R  = 4,
  parameter int C  = 8,
  parameter int WX = 4,
  parameter int WK = 8,
  parameter int AW = AW_D,
  parameter int WL = WL_D
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [WL-1:0]   cmd_k,
  input  logic [WL-1:0]   cmd_tiles,
  input  logic [AW-1:0]   cmd_x_base,
  input  logic [AW-1:0]   cmd_k_base,
  output logic            rd_en,
  output logic [AW-1:0]   x_addr,
  output logic [AW-1:0]   k_addr,
  input  logic [R*WX-1:0] x_rdata,
  input  logic [C*WK-1:0] k_rdata,
  sa_job_ctrl_if.master   feed,
  input  logic            mon_valid,
  input  logic            mon_ready,
  input  logic            mon_last,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int W = R*WX + C*WK + 1;
  state_t          state, nxt;
  logic [WL-1:0]   k_r, tiles_r, kcnt, pcnt;
  logic [AW-1:0]   xb, kb;
  logic [2*WL-1:0] total, issued;
  logic            rd_q, last_q, accept, bad, pkt, last_rd;
  logic [1:0]      occ;
  logic [W-1:0]    head;
  assign accept    = cmd_valid && cmd_ready;
  assign bad       = cmd_k == '0 || cmd_tiles == '0;
  assign pkt       = state != IDLE && mon_valid && mon_ready && mon_last;
  assign cmd_ready = rstn && state == IDLE;
  assign busy      = state != IDLE;
  // stored entries plus the read in flight never exceed the two FIFO slots
  assign rd_en     = rstn && state == FEED && issued < total && occ + 2'(rd_q) < 2'd2;
  assign last_rd   = rd_en && issued == total - (2*WL)'(1);
  assign x_addr    = xb + issued[AW-1:0];
  assign k_addr    = kb + issued[AW-1:0];
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    if (state == IDLE && accept && !bad) nxt = FEED;
    else if (state == FEED && last_rd) nxt = DRAIN;
    else if (state == DRAIN && pcnt == tiles_r && occ == 2'd0 && !rd_q) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      {k_r, tiles_r, kcnt, pcnt} <= '0;
      {xb, kb, total, issued}    <= '0;
      {rd_q, last_q, done, err}  <= '0;
    end else begin
      rd_q   <= rd_en;
      last_q <= kcnt == k_r - WL'(1);
      done   <= (accept && bad) || (state == DRAIN && nxt == IDLE);
      err    <= (accept && bad) || (state == FEED && pkt && pcnt + WL'(1) == tiles_r);
      if (accept) begin
        k_r     <= cmd_k;
        tiles_r <= cmd_tiles;
        xb      <= cmd_x_base;
        kb      <= cmd_k_base;
        total   <= (2*WL)'(cmd_k) * (2*WL)'(cmd_tiles);
        issued  <= '0;
        kcnt    <= '0;
        pcnt    <= '0;
      end
      if (rd_en) begin
        issued <= issued + (2*WL)'(1);
        kcnt   <= kcnt == k_r - WL'(1) ? '0 : kcnt + WL'(1);
      end
      if (pkt) pcnt <= pcnt + WL'(1);
    end
  end
  sa_skid_fifo #(.W(W)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (rd_q),
    .pop  (feed.s_valid && feed.s_ready),
    .din  ({last_q, x_rdata, k_rdata}),
    .valid(feed.s_valid),
    .dout (head),
    .occ  (occ)
  );
  assign feed.s_last  = head[W-1];
  assign feed.sx_data = head[C*WK +: R*WX];
  assign feed.sk_data = head[C*WK-1:0];
endmodule

// File: doc/sa_job_ctrl.md
SA_JOB_CTRL -- requirements
Module: sa_job_ctrl

Interface
REQ-001 SHALL have parameters: R, 4, array rows; C, 8, array columns; WX, 4, x element width; WK, 8, k element width; AW, 10, buffer address width; WL, 16, count width.
REQ-002 SHALL have ports: clk in 1 clock; rstn in 1 reset, synchronous, active-low.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_k in WL, beats per tile; cmd_tiles in WL, tile count; cmd_x_base in AW; cmd_k_base in AW.
REQ-004 SHALL have buffer read ports: rd_en out 1; x_addr out AW; k_addr out AW; x_rdata in R*WX; k_rdata in C*WK. Read data is valid exactly 1 cycle after rd_en.
REQ-005 SHALL have array-feed ports: s_valid out 1; s_ready in 1; s_last out 1; sx_data out R*WX; sk_data out C*WK.
REQ-006 SHALL have output-monitor ports: mon_valid in 1; mon_ready in 1; mon_last in 1, all observed only.
REQ-007 SHALL have status ports: busy out 1; done out 1, pulse; err out 1, pulse.

Function
REQ-008 SHALL implement FSM IDLE, FEED, DRAIN.
REQ-009 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready latch all cmd fields and clear counters.
REQ-010 IDLE, command accepted, cmd_k==0 or cmd_tiles==0: stay IDLE, assert done and err together for 1 cycle, issue no reads.
REQ-011 IDLE, valid command accepted: go FEED next cycle.
REQ-012 FEED: cmd_ready=0; total beats = cmd_k*cmd_tiles, computed at 2*WL bits.
REQ-013 rd_en=1 only when in FEED, beats issued < total, and (skid occupancy + reads in flight) < 2.
REQ-014 Beat i (0-based) SHALL read x_addr=x_base+i and k_addr=k_base+i, modulo 2^AW, wrapping silently.
REQ-015 Returned data SHALL be written into a 2-entry skid FIFO together with a last flag, set when (i mod cmd_k)==cmd_k-1.
REQ-016 FIFO head drives s_valid, sx_data, sk_data, s_last. Pop on s_valid&&s_ready.
REQ-017 While s_valid=1, data and s_last SHALL stay stable until accepted.
REQ-018 With s_ready held 1, the controller SHALL sustain 1 beat/cycle after a 2-cycle start latency: first rd_en 1 cycle after accept, first s_valid 1 cycle after that.
REQ-019 FEED to DRAIN SHALL occur on the cycle the last read is issued.
REQ-020 In FEED or DRAIN, output packets SHALL be counted on mon_valid&&mon_ready&&mon_last.
REQ-021 DRAIN to IDLE SHALL occur when packet count == cmd_tiles and the FIFO is empty; done pulses 1 cycle in the same cycle the FSM enters IDLE.
REQ-022 If the packet count reaches cmd_tiles while still in FEED, set err and complete normally.
REQ-023 busy=1 in FEED and DRAIN.
REQ-024 A simultaneous push and pop with 1 entry SHALL keep occupancy at 1 and preserve order.

Reset
REQ-025 rstn=0 SHALL give FSM=IDLE, FIFO empty, in-flight=0, all counters 0, latched fields 0.
REQ-026 Outputs under reset SHALL be: cmd_ready=1 after reset release, 0 during reset; rd_en=0; s_valid=0; s_last=0; done=0; err=0; busy=0; addresses=0; data=0.
REQ-027 Reset mid-job SHALL abandon the job. Read data returning on the next cycle is discarded.

Structure
REQ-028 Package sa_pkg SHALL hold the FSM state enum and the WL/AW defaults.
REQ-029 The FIFO SHALL be sub-module sa_skid_fifo: 2 entries, width R*WX+C*WK+1, push/pop/occupancy.

Verification
REQ-030 cmd_k=3, tiles=2, bases 0/0, s_ready=1 -> 6 beats, addresses 0..5, s_last on beats 2 and 5, no bubbles after the first beat.
REQ-031 Same command, s_ready toggling 1/0 each cycle -> data stable while stalled, 6 beats in order, FIFO never overflows.
REQ-032 x_base=2^AW-2, cmd_k=4, tiles=1 -> x_addr sequence 1022, 1023, 0, 1 (AW=10).
REQ-033 cmd_k=0 -> done=err=1 for 1 cycle, rd_en never asserted, cmd_ready stays 1.
REQ-034 tiles=2 with 2 mon_last handshakes after the feed completes -> done pulses 1 cycle, busy falls, next command accepted immediately.
REQ-035 rstn pulsed mid-FEED after 3 beats -> all outputs at reset values next cycle, a new command runs from beat 0.
